// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmitter: framing modes, divider clamp and frame length.
package i2s_pkg;

    localparam logic MODE_I2S = 1'b0;
    localparam logic MODE_LJ  = 1'b1;

    // A programmed divider of 0 behaves as 1 so sck never stalls.
    function automatic logic [31:0] div_clamp(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

    function automatic int frame_len(input int slot_w);
        return 2 * slot_w;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Divider and bit timing: produces sck, ws, the per-bit strobe and the next bit index.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int SLOT_W = 16,
    parameter int DIV_W  = 8,
    parameter int BW     = $clog2(frame_len(SLOT_W))
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [DIV_W-1:0] clk_div,
    output logic             strobe,
    output logic [BW-1:0]    bit_nxt,
    output logic             sck,
    output logic             ws
);

    localparam logic [BW-1:0] LAST   = BW'(frame_len(SLOT_W) - 1);
    localparam logic [BW-1:0] SLOT_B = BW'(SLOT_W);

    logic             en_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             rise;
    logic             wrap;

    assign rise    = en && !en_q;
    assign wrap    = en_q && (div_cnt == div_q - DIV_W'(1));
    // The enable cycle counts as a falling sck edge so the frame starts immediately.
    assign strobe  = rise || (en && wrap && sck);
    assign bit_nxt = (rise || bit_cnt == LAST) ? '0 : bit_cnt + BW'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en_q    <= 1'b0;
            div_q   <= DIV_W'(1);
            div_cnt <= '0;
            sck     <= 1'b0;
            ws      <= 1'b0;
            bit_cnt <= '0;
        end else if (!en) begin
            en_q    <= 1'b0;
            div_cnt <= '0;
            sck     <= 1'b0;
            ws      <= 1'b0;
            bit_cnt <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register
            // sees the pre-edge values of its neighbours, whatever the statement order.
            en_q <= 1'b1;
            if (rise || wrap) div_cnt <= '0;
            else              div_cnt <= div_cnt + DIV_W'(1);
            if (wrap) sck <= ~sck;
            if (strobe) begin
                bit_cnt <= bit_nxt;
                ws      <= (bit_nxt >= SLOT_B);
                if (bit_nxt == '0) div_q <= DIV_W'(div_clamp(32'(clk_div)));
            end
        end
    end

endmodule

// File: rtl/i2s_tx_master.sv
// I2S / left-justified transmitter: sample handshake, holding register and serialiser.
module i2s_tx_master
    import i2s_pkg::*;
#(
    parameter int DW     = 16,
    parameter int SLOT_W = 16,
    parameter int DIV_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             mode,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_left,
    input  logic [DW-1:0]    in_right,
    output logic             in_ready,
    output logic             sck,
    output logic             ws,
    output logic             sd,
    output logic             underrun
);

    localparam int            BW     = $clog2(frame_len(SLOT_W));
    localparam logic [BW-1:0] LAST   = BW'(frame_len(SLOT_W) - 1);
    localparam logic [BW-1:0] SLOT_B = BW'(SLOT_W);
    localparam logic [BW-1:0] DW_B   = BW'(DW);

    logic          strobe;
    logic [BW-1:0] bit_nxt;
    logic          mode_q;
    logic [DW-1:0] hold_l, hold_r;
    logic [DW-1:0] frm_l, frm_r;

    logic          cfg_start, mode_eff, load, ch_r, sd_nxt;
    logic [BW-1:0] p_nxt, q;
    logic [DW-1:0] cur_l, cur_r, word, shifted;

    i2s_clkgen #(.SLOT_W(SLOT_W), .DIV_W(DIV_W), .BW(BW)) u_clkgen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clk_div (clk_div),
        .strobe  (strobe),
        .bit_nxt (bit_nxt),
        .sck     (sck),
        .ws      (ws)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned and infers a latch.
        cur_l     = frm_l;
        cur_r     = frm_r;
        cfg_start = strobe && (bit_nxt == '0);
        mode_eff  = cfg_start ? mode : mode_q;
        if (mode_eff == MODE_LJ)   p_nxt = bit_nxt;
        else if (bit_nxt == '0)    p_nxt = LAST;
        else                       p_nxt = bit_nxt - BW'(1);
        load = strobe && (p_nxt == '0);
        if (load) begin
            cur_l = in_ready ? '0 : hold_l;
            cur_r = in_ready ? '0 : hold_r;
        end
        ch_r    = (p_nxt >= SLOT_B);
        q       = ch_r ? p_nxt - SLOT_B : p_nxt;
        word    = ch_r ? cur_r : cur_l;
        shifted = word << q;
        sd_nxt  = (q < DW_B) ? shifted[DW-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q   <= MODE_I2S;
            hold_l   <= '0;
            hold_r   <= '0;
            in_ready <= 1'b1;
            frm_l    <= '0;
            frm_r    <= '0;
            sd       <= 1'b0;
            underrun <= 1'b0;
        end else begin
            // A load empties a full register; a same-cycle transfer only lands when it was empty.
            if (load && !in_ready) begin
                in_ready <= 1'b1;
            end else if (in_valid && in_ready) begin
                hold_l   <= in_left;
                hold_r   <= in_right;
                in_ready <= 1'b0;
            end
            // Clearing the frame while idle makes the first I2S bit after enable a 0.
            if (!en) begin
                sd       <= 1'b0;
                underrun <= 1'b0;
                frm_l    <= '0;
                frm_r    <= '0;
            end else begin
                underrun <= load && in_ready;
                if (cfg_start) mode_q <= mode;
                if (load) begin
                    frm_l <= cur_l;
                    frm_r <= cur_r;
                end
                if (strobe) sd <= sd_nxt;
            end
        end
    end

endmodule
